gba_fb_writer: RTL and testbench

Write-side controller for the GBA frame double buffer. Accepts the graphics pipeline's 240x160 15-bit BGR555 pixel stream over a valid/ready handshake, writes it raster-order into the back buffer, and swaps front/back buffers at the next vertical blank once a full frame is written. The VGA scan-out side reads only the front buffer, using `disp_base` as its address offset.

---
 rtl/gba_gfx_pkg.sv | 27 ++
 rtl/fb_pix_counter.sv | 34 +++
 rtl/gba_fb_writer.sv | 133 +++++++++++++
 tb/tb_gba_fb_writer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/gba_gfx_pkg.sv
// Shared graphics constants and types for the GBA frame double buffer.
// Used by both the write-side controller and the VGA scan-out side.
package gba_gfx_pkg;

  localparam int FB_COLS   = 240;
  localparam int FB_ROWS   = 160;
  localparam int FB_PIXELS = FB_COLS * FB_ROWS;
  localparam int FB_ADDR_W = 17;
  localparam int COLOR_W   = 15;

  // BGR555 pixel color
  typedef logic [COLOR_W-1:0]   color15_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef enum logic {
    FBW_WRITE     = 1'b0,
    FBW_WAIT_SWAP = 1'b1
  } fbw_state_t;

  localparam fb_addr_t FB_LAST_IDX = fb_addr_t'(FB_PIXELS - 1);

  // Base address of buffer 0 or buffer 1 in the shared RAM
  function automatic fb_addr_t fb_base(input logic i_buf_sel);
    return i_buf_sel ? fb_addr_t'(FB_PIXELS) : '0;
  endfunction

endpackage

// File: rtl/fb_pix_counter.sv
// Wrapping linear pixel index counter, 0..FB_PIXELS-1.
// An enabled clear (start-of-frame pixel) counts as index 0, so the
// counter lands on 1 afterwards.
module fb_pix_counter
  import gba_gfx_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     i_clr,
  input  logic     i_en,
  output fb_addr_t o_idx,
  output logic     o_tc
);

  fb_addr_t r_idx;

  assign o_idx = r_idx;
  assign o_tc  = (r_idx == FB_LAST_IDX);

  // Index advances once per accepted pixel, wrapping at the last pixel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (i_en) begin
      if (i_clr)
        r_idx <= fb_addr_t'(1);
      else if (o_tc)
        r_idx <= '0;
      else
        r_idx <= r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/gba_fb_writer.sv
// Write-side controller for the GBA frame double buffer.
// Streams 240x160 BGR555 pixels into the back buffer and swaps buffers.
// Build option FB_VBLANK_SWAP_EN: when defined, a completed frame waits
// for vblank_start before the swap; otherwise it swaps immediately.
module gba_fb_writer
  import gba_gfx_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [14:0] pix_data,
  output logic        pix_ready,
  input  logic        vblank_start,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [14:0] wr_data,
  output logic        disp_buf,
  output logic [16:0] disp_base,
  output logic        frame_swapped
);

  fbw_state_t r_state;
  fbw_state_t w_state_nx;

  logic     w_ready;
  logic     w_accept;
  logic     w_final;
  logic     w_swap;
  logic     w_tc;
  fb_addr_t w_idx;
  fb_addr_t w_idx_sel;
  fb_addr_t w_addr;

  logic     r_disp_buf;
  logic     r_frame_swapped;
  logic     r_wr_en_p1;
  fb_addr_t r_wr_addr_p1;
  color15_t r_wr_data_p1;

`ifdef FB_VBLANK_SWAP_EN
  assign w_ready = (r_state == FBW_WRITE);
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank_start;
  assign w_ready = 1'b1;
`endif

  assign w_accept  = pix_valid && w_ready;
  assign w_idx_sel = pix_sof ? '0 : w_idx;
  assign w_addr    = fb_base(~r_disp_buf) + w_idx_sel;
  assign w_final   = w_accept && !pix_sof && w_tc;

  fb_pix_counter u_pix_counter (
    .clock (clock),
    .reset (reset),
    .i_clr (pix_sof),
    .i_en  (w_accept),
    .o_idx (w_idx),
    .o_tc  (w_tc)
  );

  // Next-state and swap decision
  always_comb begin
    w_state_nx = r_state;
    w_swap     = 1'b0;
    case (r_state)
      FBW_WRITE: begin
        if (w_final) begin
`ifdef FB_VBLANK_SWAP_EN
          w_state_nx = FBW_WAIT_SWAP;
`else
          w_swap = 1'b1;
`endif
        end
      end
      FBW_WAIT_SWAP: begin
`ifdef FB_VBLANK_SWAP_EN
        if (vblank_start) begin
          w_swap     = 1'b1;
          w_state_nx = FBW_WRITE;
        end
`else
        w_state_nx = FBW_WRITE;
`endif
      end
      default: w_state_nx = FBW_WRITE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_state <= FBW_WRITE;
    else
      r_state <= w_state_nx;
  end

  // Front/back selection toggles on each swap, with a one-cycle pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_disp_buf      <= 1'b0;
      r_frame_swapped <= 1'b0;
    end else begin
      r_disp_buf      <= r_disp_buf ^ w_swap;
      r_frame_swapped <= w_swap;
    end
  end

  // Stage p0 -> p1: registered RAM write, one strobe per accepted pixel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_en_p1   <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end else begin
      r_wr_en_p1 <= w_accept;
      if (w_accept) begin
        r_wr_addr_p1 <= w_addr;
        r_wr_data_p1 <= pix_data;
      end
    end
  end

  assign pix_ready     = w_ready;
  assign wr_en         = r_wr_en_p1;
  assign wr_addr       = r_wr_addr_p1;
  assign wr_data       = r_wr_data_p1;
  assign disp_buf      = r_disp_buf;
  assign disp_base     = fb_base(r_disp_buf);
  assign frame_swapped = r_frame_swapped;

endmodule

// File: tb/tb_gba_fb_writer.sv
// Scoreboard bench for gba_fb_writer: randomized pixel stream, reference
// model of the double buffer, and an independent output monitor.
module tb_gba_fb_writer;

`ifdef FB_VBLANK_SWAP_EN
  localparam bit VB_EN = 1'b1;
`else
  localparam bit VB_EN = 1'b0;
`endif
  localparam int NPIX = 38400;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [14:0] pix_data = '0;
  logic        pix_ready;
  logic        vblank_start = 1'b0;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [14:0] wr_data;
  logic        disp_buf;
  logic [16:0] disp_base;
  logic        frame_swapped;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          m_idx = 0;
  bit          m_disp = 1'b0;
  bit          m_waiting = 1'b0;
  bit          m_swap = 1'b0;
  logic [31:0] q[$];

  gba_fb_writer dut (
    .clock(clock), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .pix_ready(pix_ready), .vblank_start(vblank_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .disp_buf(disp_buf),
    .disp_base(disp_base), .frame_swapped(frame_swapped)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Reference model: buffer bookkeeping from the frame rules
  initial begin
    int i;
    forever begin
      @(posedge clock);
      m_swap = 1'b0;
      if (reset) begin
        m_idx = 0; m_disp = 1'b0; m_waiting = 1'b0; q.delete();
      end else if (pix_valid && !m_waiting) begin
        i = pix_sof ? 0 : m_idx;
        q.push_back({(m_disp ? 17'd0 : 17'(NPIX)) + 17'(i), pix_data});
        m_idx = i + 1;
        if (m_idx == NPIX) begin
          m_idx = 0;
          if (VB_EN) m_waiting = 1'b1;
          else begin m_disp = ~m_disp; m_swap = 1'b1; end
        end
      end else if (m_waiting && vblank_start) begin
        m_disp = ~m_disp; m_waiting = 1'b0; m_swap = 1'b1;
      end
    end
  end

  // Monitor: compares DUT outputs just after each active edge
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clock);
      #1;
      chk("pix_ready", 32'(pix_ready), 32'(!m_waiting));
      chk("disp_buf", 32'(disp_buf), 32'(m_disp));
      chk("disp_base", 32'(disp_base), m_disp ? 32'(NPIX) : 32'd0);
      chk("frame_swapped", 32'(frame_swapped), 32'(m_swap));
      if (wr_en) begin
        if (q.size() == 0) chk("spurious_write", 32'(wr_addr), 32'hFFFF_FFFF);
        else begin
          e = q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e[31:15]));
          chk("wr_data", 32'(wr_data), 32'(e[14:0]));
          chk("wr_addr_range", 32'(wr_addr <= 17'd76799), 32'd1);
        end
      end else if (q.size() != 0) begin
        e = q.pop_front();
        chk("missing_write", 32'(wr_en), 32'd1);
      end
    end
  end

  task automatic push_px(input bit sof, input bit vb, input int gap, input logic [14:0] d);
    int  tries = 0;
    bit  done = 0;
    while (!done) begin
      @(negedge clock);
      pix_valid    = ($urandom_range(99) >= gap);
      pix_sof      = sof;
      pix_data     = pix_valid ? d : 15'($urandom);
      vblank_start = 1'b0;
      if (pix_valid && pix_ready) begin
        done = 1;
        vblank_start = vb;
      end
      tries++;
      if (!done && tries > 500) begin
        tests++; fails++;
        $display("FAIL ready_timeout got=%0d expected=1", pix_ready);
        done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      pix_valid = 1'b0; pix_sof = 1'b0; vblank_start = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_disp_buf"}, 32'(disp_buf), 32'd0);
    chk({tag, "_disp_base"}, 32'(disp_base), 32'd0);
    chk({tag, "_frame_swapped"}, 32'(frame_swapped), 32'd0);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd1);
  endtask

  // Stimulus
  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1 chk_reset_vals("rst0");

    // Partial frame with 50% valid gaps, then abandoned by a new sof
    push_px(1'b1, 1'b0, 50, 15'($urandom));
    for (int k = 1; k < 1000; k++) push_px(1'b0, 1'b0, 50, 15'($urandom));
    push_px(1'b1, 1'b0, 0, 15'h7FFF);
    for (int k = 1; k < NPIX - 1; k++)
      push_px(1'b0, ($urandom_range(999) == 0), 12, 15'($urandom));
    // Final pixel with a coincident vblank_start, which must not swap
    push_px(1'b0, 1'b1, 0, 15'($urandom));
    idle(100);
    @(negedge clock);
    pix_valid = 1'b0; vblank_start = 1'b1;
    idle(3);

    // Next frame targets buffer 0; interrupted by reset
    push_px(1'b1, 1'b0, 0, 15'($urandom));
    for (int k = 1; k < 20000; k++) push_px(1'b0, 1'b0, 0, 15'($urandom));
    @(negedge clock);
    pix_valid = 1'b0;
    reset = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(negedge clock);
    reset = 1'b0;

    // Fresh frame after reset lands in buffer 1
    push_px(1'b1, 1'b0, 30, 15'($urandom));
    for (int k = 1; k < 300; k++) push_px(1'b0, 1'b0, 30, 15'($urandom));
    idle(5);
    chk("drain", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
